// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and helpers used by the fetch stage.
package riscv_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [6:0]      OPC_BRANCH       = 7'b1100011;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/branch_predecode.sv
// Static predictor: backward conditional branches are predicted taken.
module branch_predecode
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  output logic            pred,
  output logic [XLEN-1:0] target
);

  logic [12:0]     b_imm;
  logic [XLEN-1:0] b_offset;
  logic            unused_fields;

  assign b_imm         = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign b_offset      = {{(XLEN-13){b_imm[12]}}, b_imm};
  assign pred          = (instr[6:0] == OPC_BRANCH) && instr[31];
  assign target        = pc + b_offset;
  assign unused_fields = ^instr[24:12];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, IMEM addressing and the IF/ID pipeline register.
// Optional static branch prediction is enabled by defining STATIC_PREDICT_EN.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              IMEM_WORDS = 64
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_instr,
  output logic            ifid_pred_taken,
  output logic            misaligned_err
);

  // One extra bit so IMEM_WORDS*4 == 2^32 would still compare correctly.
  localparam logic [XLEN:0] IMEM_BYTES = (XLEN+1)'(IMEM_WORDS) << 2;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] fw;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] pred_target;
  logic [XLEN-1:0] next_pc;
  logic            pred_taken;
  logic            in_range;

  assign imem_addr = pc_q;
  assign in_range  = ({1'b0, pc_q} < IMEM_BYTES);
  assign fw        = in_range ? imem_rdata : NOP_INSTR;
  assign seq_pc    = pc_q + XLEN'(4);

`ifdef STATIC_PREDICT_EN
  branch_predecode u_predecode (
    .instr  (fw),
    .pc     (pc_q),
    .pred   (pred_taken),
    .target (pred_target)
  );
`else
  assign pred_taken  = 1'b0;
  assign pred_target = '0;
`endif

  // Branch offsets are only 2-byte aligned; keep the PC word-aligned regardless.
  assign next_pc = pred_taken ? word_align(pred_target) : seq_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q            <= word_align(RESET_PC);
      ifid_valid      <= 1'b0;
      ifid_pc         <= '0;
      ifid_instr      <= NOP_INSTR;
      ifid_pred_taken <= 1'b0;
      misaligned_err  <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= word_align(redirect_pc);
      ifid_valid <= 1'b0;
      if (|redirect_pc[1:0]) begin
        misaligned_err <= 1'b1;
      end
    end else if (!stall) begin
      pc_q            <= next_pc;
      ifid_valid      <= 1'b1;
      ifid_pc         <= pc_q;
      ifid_instr      <= fw;
      ifid_pred_taken <= pred_taken;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference model pushes the expected post-edge
// state each cycle and an independent monitor pops and compares after every edge.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        pred;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_pred_taken;
  logic        misaligned_err;

  logic [31:0] mem [64];
  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;

  logic [31:0] m_pc, m_ipc, m_instr;
  logic        m_valid, m_pred, m_err;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .ifid_valid      (ifid_valid),
    .ifid_pc         (ifid_pc),
    .ifid_instr      (ifid_instr),
    .ifid_pred_taken (ifid_pred_taken),
    .misaligned_err  (misaligned_err)
  );

  // Memory aliases out-of-range addresses, so the DUT must substitute NOP itself.
  assign imem_rdata = mem[imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset();
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(ifid_valid), 32'h0);
    check("rst_ifid_pc", ifid_pc, 32'h0);
    check("rst_ifid_instr", ifid_instr, NOP);
    check("rst_pred", 32'(ifid_pred_taken), 32'h0);
    check("rst_err", 32'(misaligned_err), 32'h0);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_instr = NOP;
    m_pred = 1'b0; m_err = 1'b0;
  endtask

  // One clock of stimulus; called at posedge+2, returns at the next posedge+2.
  task automatic cycle(input logic st, input logic rv, input logic [31:0] rpc);
    logic [31:0] fw, tgt;
    logic [12:0] off;
    logic        p;
    exp_t        e;
    stall = st; redirect_valid = rv; redirect_pc = rpc;
    fw  = (m_pc < 32'd256) ? mem[m_pc[7:2]] : NOP;
    p   = 1'b0;
    tgt = m_pc + 32'd4;
`ifdef STATIC_PREDICT_EN
    off = {fw[31], fw[7], fw[30:25], fw[11:8], 1'b0};
    if (fw[6:0] == 7'h63 && fw[31]) begin
      p   = 1'b1;
      tgt = (m_pc + {{19{off[12]}}, off}) & 32'hFFFF_FFFC;
    end
`else
    off = 13'h0;
`endif
    if (rv) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      if (rpc[1:0] != 2'b00) m_err = 1'b1;
    end else if (!st) begin
      m_ipc = m_pc; m_instr = fw; m_valid = 1'b1; m_pred = p;
      m_pc = tgt;
    end
    e = '{addr: m_pc, valid: m_valid, ipc: m_ipc, instr: m_instr, pred: m_pred, err: m_err};
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("imem_addr", imem_addr, e.addr);
        check("ifid_valid", 32'(ifid_valid), 32'(e.valid));
        check("ifid_pc", ifid_pc, e.ipc);
        check("ifid_instr", ifid_instr, e.instr);
        check("ifid_pred_taken", 32'(ifid_pred_taken), 32'(e.pred));
        check("misaligned_err", 32'(misaligned_err), 32'(e.err));
      end
    end
  end

  initial begin : driver
    logic [31:0] rpc;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0020_0193;
    mem[3] = 32'h0030_0213;
    mem[4] = 32'h0040_0293;
    mem[5] = 32'hFE00_0EE3;
    mem[40] = 32'hFE00_0CE3;
    mem[50] = 32'hFC00_08E3;

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_reset();
    reset = 1'b0;

    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h10);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h16);
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'hF4);
    repeat (6) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'hFFFF_FFF4);
    repeat (5) cycle(1'b0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of activity, away from any clock edge.
    redirect_valid = 1'b1; stall = 1'b1; redirect_pc = 32'h40;
    reset = 1'b1;
    #1;
    check_reset();
    model_reset();
    @(posedge clk);
    #2;
    check_reset();
    reset = 1'b0;

    for (int n = 0; n < 400; n++) begin
      case ($urandom % 4)
        0: rpc = 32'($urandom_range(0, 70)) << 2;
        1: rpc = 32'($urandom_range(0, 300));
        2: rpc = $urandom;
        default: rpc = 32'hFFFF_FFF0;
      endcase
      // Keep the first stretch aligned so the sticky flag is seen clear for a while.
      if (n < 100) rpc = rpc & 32'hFFFF_FFFC;
      cycle(($urandom % 4) == 0, ($urandom % 10) == 0, rpc);
    end

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the program counter, drives the instruction memory read address, and registers the returned word into the IF/ID pipeline register for the decoder. It sits directly upstream of the instruction memory and between it and decode. It handles pipeline stalls, redirects from execute (branch/jump resolution and flush), and optional static branch prediction.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_WORDS, 64: instruction memory depth in 32-bit words; fetches at or beyond IMEM_WORDS*4 return NOP.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory, equal to current PC (combinational from PC register).
- imem_rdata  in  32  instruction word returned combinationally by instruction memory for imem_addr.
- stall  in  1  hold PC and IF/ID contents this cycle.
- redirect_valid  in  1  execute requests PC change and flush.
- redirect_pc  in  32  target byte address for the redirect.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_pc  out  32  PC of the registered instruction.
- ifid_instr  out  32  registered instruction word.
- ifid_pred_taken  out  1  fetch predicted this instruction taken (0 when the prediction feature is absent).
- misaligned_err  out  1  sticky flag; a redirect target had nonzero bits [1:0].

## Operation
- PC register is word-aligned; bits [1:0] are always 0.
- Fetched word fw = NOP (32'h0000_0013) when PC >= IMEM_WORDS*4, else imem_rdata.
- Sequential next PC = PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Per rising edge, priority reset > redirect > stall > advance:
  - redirect_valid=1: PC <= {redirect_pc[31:2],2'b00}; ifid_valid <= 0; other IF/ID fields hold. If redirect_pc[1:0]!=0, misaligned_err <= 1. Redirect overrides a simultaneous stall.
  - stall=1, no redirect: PC and all IF/ID outputs hold.
  - advance: ifid_pc <= PC; ifid_instr <= fw; ifid_valid <= 1; ifid_pred_taken <= pred; PC <= predicted target if pred, else PC + 4.
- misaligned_err clears only on reset.
- No internal state machine beyond PC, IF/ID register and sticky flag; decode consumes IF/ID directly.

## Timing
- Reset values: PC=RESET_PC, imem_addr=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_instr=32'h0000_0013, ifid_pred_taken=0, misaligned_err=0.
- Reset asserted mid-operation clears all state immediately (asynchronous), regardless of stall or redirect.
- Latency: PC->imem_addr 0 cycles; instruction at PC visible on IF/ID 1 cycle after PC is registered. First valid IF/ID at the first edge after reset deasserts.
- Redirect: one bubble (ifid_valid=0) in the cycle after the redirect edge; target instruction valid on the following edge.
- Steady state: one instruction per cycle with stall=0.

## Configuration
- STATIC_PREDICT_EN defined: fw is predecoded; if opcode fw[6:0]=7'b1100011 (B-type) and fw[31]=1 (backward offset), pred=1 and target = PC + sext({fw[31],fw[7],fw[30:25],fw[11:8],1'b0}), modulo 2^32. Execute issues the redirect on mispredict.
- Not defined: pred is constant 0, next PC is always PC+4 unless redirected, ifid_pred_taken tied 0.

## Structure
- Shared package riscv_pkg: NOP_INSTR (32'h0000_0013), OPC_BRANCH (7'b1100011), XLEN (32), default RESET_PC.
- One sub-module branch_predecode: combinational; inputs instruction and PC, outputs pred and target. Instantiated only under STATIC_PREDICT_EN.

## Test plan
- Reset then free-run with memory words 0..5 loaded: IF/ID shows pc 0,4,8,… with matching words on consecutive cycles, ifid_valid=1 from the first post-reset edge.
- stall=1 for 3 cycles at PC=8: imem_addr stays 8, IF/ID holds pc=4 instr word1; resumes with pc=8 after release.
- redirect_valid=1, redirect_pc=0x10, with stall=1: next cycle ifid_valid=0, PC=0x10; following cycle ifid_pc=0x10.
- redirect_pc=0x0000_0016: PC becomes 0x14, misaligned_err=1 and stays 1 until reset.
- PC reaches 0x100 (IMEM_WORDS=64): ifid_instr=32'h0000_0013, valid=1; PC=0xFFFF_FFFC advances to 0.
- STATIC_PREDICT_EN, word at 0x14 = 32'hFE000EE3 (beq x0,x0,-4): ifid_pred_taken=1, next fetched pc=0x10; without macro next pc=0x18.
